axi_csr_fifo_top: RTL and testbench
===================================

# axi_csr_fifo_top

AXI4-Lite-controlled synchronous FIFO subsystem. A CSR block behind an AXI4-Lite slave port gates a FIFO core through a CONTROL register and reports FIFO occupancy and flags through a STATUS register. FIFO data moves over a separate sideband push/pop interface. The block sits on the peripheral bus as a memory-mapped streaming buffer.

## Interface
- ADDR_WIDTH, 12, AXI address width (byte addresses).
- DATA_WIDTH, 32, AXI data width and FIFO word width.
- FIFO_DEPTH, 16, number of FIFO entries; must be a power of two ≥ 2.
- ACLK  in  1  single system clock; all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- S_AXI_AWADDR / AWVALID / AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / ARVALID / ARREADY  in/in/out  ADDR_WIDTH/1/1  read address channel.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- wr_en  in  1  FIFO push request.
- rd_en  in  1  FIFO pop request.
- data_in  in  DATA_WIDTH  push data.
- data_out  out  DATA_WIDTH  registered pop data.

## Operation
- Register map, decoded on ADDR[ADDR_WIDTH-1:2], with ADDR[1:0] ignored:
  - 0x000 CONTROL, RW. Bit 0 is fifo_en (reset 0). Other bits are reserved, read 0, writes ignored.
  - 0x004 STATUS, RO. Bit 0 fifo_empty, bit 1 fifo_full, bits [8+L-1:8] fifo_level, where L = clog2(FIFO_DEPTH)+1 (bits [12:8] by default). All other bits read 0.
  - Any other address reads 0. Writes to STATUS or unmapped addresses are ignored.
  - BRESP and RRESP are always OKAY (2'b00).
- WSTRB[0] must be set for a CONTROL write to update fifo_en.
- Push occurs when wr_en && fifo_en && !full: data_in is stored at the write pointer and the write pointer advances.
- Pop occurs when rd_en && fifo_en && !empty: the entry at the read pointer is registered onto data_out and the read pointer advances. Otherwise data_out holds its value.
- Simultaneous push and pop are both performed when each is individually legal; level is unchanged.
- Push when full is dropped, with no state change. Pop when empty is dropped, and data_out holds.
- fifo_en = 0 ignores wr_en and rd_en. Contents and level are retained.
- Pointers are clog2(FIFO_DEPTH) bits and wrap naturally modulo FIFO_DEPTH.
- level is 0..FIFO_DEPTH. empty = (level == 0); full = (level == FIFO_DEPTH).

## Timing
- Reset values:
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0.
  - BRESP, RRESP, RDATA = 0.
  - data_out = 0.
  - Pointers and level = 0; empty = 1; full = 0; fifo_en = 0.
- Write handshake:
  - AWREADY and WREADY assert together for exactly one cycle in the cycle after AWVALID && WVALID are both high, provided AWREADY = 0 and BVALID = 0.
  - The CONTROL update takes effect on that same handshake edge.
  - BVALID asserts on the following edge and holds until BREADY is sampled high.
  - No new write is accepted while BVALID = 1.
- Read handshake:
  - ARREADY asserts for one cycle in the cycle after ARVALID is high, provided ARREADY = 0 and RVALID = 0.
  - RVALID and RDATA are registered on the following edge. RDATA is the register value at the handshake.
  - RVALID holds until RREADY is sampled high, and RDATA is stable while RVALID = 1.
- A master that keeps VALID high for one extra cycle after READY must not cause a second transfer.
- FIFO pushes and pops take effect on the sampling edge; level, empty and full update on that same edge.
- A pushed word is poppable on the next cycle.
- STATUS reflects the FIFO state as of the AR handshake edge.
- Reset asserted mid-transaction aborts the transaction and clears all state immediately. No partial response is emitted after reset deasserts.

## Structure
- Package axi_csr_fifo_pkg holds:
  - CONTROL_ADDR = 12'h000 and STATUS_ADDR = 12'h004.
  - Bit positions FIFO_EN_BIT = 0, EMPTY_BIT = 0, FULL_BIT = 1, LEVEL_LSB = 8.
  - AXI_RESP_OKAY = 2'b00.
- Sub-module sync_fifo (parameters DATA_WIDTH, FIFO_DEPTH) holds storage, pointers, level and flags. The top holds the AXI slave and CSR logic, and gates sync_fifo's wr_en and rd_en with fifo_en.

## Test plan
- Reset, then read STATUS. Expect 0x0000_0001 (empty, level 0), RRESP = OKAY.
- Before enabling, push 1 word, then read STATUS. Expect 0x0000_0001 (push ignored).
- Write CONTROL = 0x1, then push 1, 2, 3, 4, 5 with wr_en pulsed once each, then read STATUS. Expect 0x0000_0500. Reading CONTROL returns 0x0000_0001.
- Pop 5 words. Expect data_out = 1, 2, 3, 4, 5 in order. STATUS then reads 0x0000_0001, and a further pop leaves data_out = 5.
- Push 17 distinct words. Expect STATUS = 0x0000_1002 (full, level 16) and the 17th word dropped. Popping 16 words returns the first 16, covering pointer wrap-around.
- With level 4, assert push and pop together for 3 cycles. Expect level to stay 4 and FIFO order to be preserved. Hold AWVALID/WVALID one cycle past READY and expect a single BVALID pulse.

Source files
------------

// File: rtl/axi_csr_fifo_pkg.sv
// Shared register map, CSR bit positions and AXI response codes for the
// AXI-controlled FIFO subsystem.
package axi_csr_fifo_pkg;

  localparam logic [11:0] CONTROL_ADDR  = 12'h000;
  localparam logic [11:0] STATUS_ADDR   = 12'h004;

  localparam int          FIFO_EN_BIT   = 0;
  localparam int          EMPTY_BIT     = 0;
  localparam int          FULL_BIT      = 1;
  localparam int          LEVEL_LSB     = 8;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    REG_CONTROL,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  // Decodes a word index (byte address with the two low bits already dropped).
  function automatic reg_sel_e decode_reg(input logic [31:0] word_idx);
    if (word_idx == 32'(CONTROL_ADDR >> 2))     return REG_CONTROL;
    else if (word_idx == 32'(STATUS_ADDR >> 2)) return REG_STATUS;
    else                                        return REG_NONE;
  endfunction

endpackage

// File: rtl/axi_csr_fifo_sync_fifo.sv
// Single-clock FIFO core: storage, wrapping pointers, occupancy level and
// flags, with a registered pop data output.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic                               rd_en,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [$clog2(FIFO_DEPTH):0]        level,
  output logic                               empty,
  output logic                               full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // NOTE: storage has no reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      data_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axi_csr_fifo_top.sv
// AXI4-Lite CSR slave that enables a sideband push/pop FIFO through CONTROL
// and reports its occupancy and flags through STATUS.
module axi_csr_fifo_top
  import axi_csr_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  fifo_en;
  logic [LVL_W-1:0]      level;
  logic                  empty;
  logic                  full;
  logic                  w_hs;
  logic                  ar_hs;
  reg_sel_e              aw_sel;
  reg_sel_e              ar_sel;
  logic [DATA_WIDTH-1:0] read_word;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .wr_en    (wr_en && fifo_en),
    .rd_en    (rd_en && fifo_en),
    .data_in  (data_in),
    .data_out (data_out),
    .level    (level),
    .empty    (empty),
    .full     (full)
  );

  // AWREADY and WREADY always rise together, so one ready qualifies both channels.
  assign w_hs        = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign ar_hs       = S_AXI_ARREADY && S_AXI_ARVALID;
  assign aw_sel      = decode_reg(32'(S_AXI_AWADDR[ADDR_WIDTH-1:2]));
  assign ar_sel      = decode_reg(32'(S_AXI_ARADDR[ADDR_WIDTH-1:2]));
  assign S_AXI_BRESP = AXI_RESP_OKAY;
  assign S_AXI_RRESP = AXI_RESP_OKAY;

  // NOTE: every path assigns read_word after its default, so no latch is inferred.
  always_comb begin
    read_word = '0;
    unique case (ar_sel)
      REG_CONTROL: read_word[FIFO_EN_BIT] = fifo_en;
      REG_STATUS: begin
        read_word[EMPTY_BIT]               = empty;
        read_word[FULL_BIT]                = full;
        read_word[LEVEL_LSB +: LVL_W]      = level;
      end
      default: read_word = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      fifo_en       <= 1'b0;
    end else begin
      S_AXI_AWREADY <= !S_AXI_AWREADY && !S_AXI_BVALID && S_AXI_AWVALID && S_AXI_WVALID;
      S_AXI_WREADY  <= !S_AXI_AWREADY && !S_AXI_BVALID && S_AXI_AWVALID && S_AXI_WVALID;
      if (w_hs) begin
        S_AXI_BVALID <= 1'b1;
        if (aw_sel == REG_CONTROL && S_AXI_WSTRB[0]) fifo_en <= S_AXI_WDATA[FIFO_EN_BIT];
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= !S_AXI_ARREADY && !S_AXI_RVALID && S_AXI_ARVALID;
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= read_word;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Byte-offset bits, reserved data bits and upper strobes carry no meaning here.
  logic unused;
  assign unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                    S_AXI_WDATA[DATA_WIDTH-1:1], S_AXI_WSTRB[DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_axi_csr_fifo_top.sv
// Randomised scoreboard bench for axi_csr_fifo_top: stimulus tasks queue expected
// responses from a queue-based FIFO model; monitors compare when the DUT responds.
module tb_axi_csr_fifo_top;
  import axi_csr_fifo_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int D  = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic          S_AXI_AWVALID = 1'b0;
  logic          S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY = 1'b1;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic          S_AXI_ARVALID = 1'b0;
  logic          S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;

  axi_csr_fifo_top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out)
  );

  always #5 ACLK = ~ACLK;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] exp_dout[$];
  int            exp_b = 0;

  // Reference model: FIFO as a bounded queue plus the enable bit and last popped word.
  bit            model_en = 1'b0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_reg(input logic [AW-1:0] a);
    int n = model_q.size();
    case (a >> 2)
      0:       return DW'(model_en);
      1:       return DW'(n == 0) | (DW'(n == D) << 1) | (DW'(n) << 8);
      default: return '0;
    endcase
  endfunction

  // Monitors: compare whenever the DUT presents a response.
  logic          rd_seen;
  logic [DW-1:0] mon_e;
  always @(posedge ACLK) rd_seen <= rd_en;

  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (exp_rd.size() == 0) check("rvalid_unexpected", DW'(S_AXI_RVALID), '0);
        else begin
          mon_e = exp_rd.pop_front();
          check("rdata", S_AXI_RDATA, mon_e);
          check("rresp", DW'(S_AXI_RRESP), DW'(AXI_RESP_OKAY));
        end
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (exp_b == 0) check("bvalid_unexpected", DW'(S_AXI_BVALID), '0);
        else begin
          exp_b--;
          check("bresp", DW'(S_AXI_BRESP), DW'(AXI_RESP_OKAY));
        end
      end
      if (rd_seen === 1'b1) begin
        if (exp_dout.size() == 0) check("dout_unexpected", DW'(exp_dout.size()), 32'd1);
        else begin
          mon_e = exp_dout.pop_front();
          check("data_out", data_out, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input bit hold);
    int n = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    exp_b++;
    if ((a >> 2) == 0 && s[0]) model_en = d[0];
    do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
    if (!S_AXI_AWREADY) check("awready_timeout", DW'(S_AXI_AWREADY), 32'd1);
    check("wready_with_awready", DW'(S_AXI_WREADY), DW'(S_AXI_AWREADY));
    tick();
    if (hold) tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (exp_b != 0 && n < 20) begin tick(); n++; end
    if (exp_b != 0) check("bvalid_timeout", DW'(exp_b), '0);
    exp_b = 0;
    repeat (2) tick();
  endtask

  task automatic axi_read(input logic [AW-1:0] a);
    int n = 0;
    exp_rd.push_back(model_reg(a));
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    if (!S_AXI_ARREADY) check("arready_timeout", DW'(S_AXI_ARREADY), 32'd1);
    tick();
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (exp_rd.size() != 0 && n < 20) begin tick(); n++; end
    if (exp_rd.size() != 0) check("rvalid_timeout", DW'(exp_rd.size()), '0);
    exp_rd.delete();
    tick();
  endtask

  task automatic fifo_op(input bit wr, input bit rd, input logic [DW-1:0] din);
    bit can_push = model_en && wr && model_q.size() < D;
    bit can_pop  = model_en && rd && model_q.size() > 0;
    wr_en = wr; rd_en = rd; data_in = din;
    if (can_pop) model_dout = model_q.pop_front();
    if (can_push) model_q.push_back(din);
    if (rd) exp_dout.push_back(model_dout);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    check("rst_awready", DW'(S_AXI_AWREADY), '0);
    check("rst_wready",  DW'(S_AXI_WREADY),  '0);
    check("rst_bvalid",  DW'(S_AXI_BVALID),  '0);
    check("rst_arready", DW'(S_AXI_ARREADY), '0);
    check("rst_rvalid",  DW'(S_AXI_RVALID),  '0);
    check("rst_rdata",   S_AXI_RDATA,        '0);
    check("rst_dout",    data_out,           '0);
    tick();

    axi_read(STATUS_ADDR);
    fifo_op(1'b1, 1'b0, 32'hDEAD_BEEF);
    axi_read(STATUS_ADDR);

    axi_write(CONTROL_ADDR, 32'h1, 4'hF, 1'b0);
    for (int i = 1; i <= 5; i++) fifo_op(1'b1, 1'b0, DW'(i));
    axi_read(STATUS_ADDR);
    axi_read(CONTROL_ADDR);
    for (int i = 0; i < 5; i++) fifo_op(1'b0, 1'b1, '0);
    axi_read(STATUS_ADDR);
    fifo_op(1'b0, 1'b1, '0);

    for (int i = 0; i < 17; i++) fifo_op(1'b1, 1'b0, 32'hA000 + DW'(i));
    axi_read(STATUS_ADDR);
    for (int i = 0; i < 16; i++) fifo_op(1'b0, 1'b1, '0);
    axi_read(STATUS_ADDR);

    for (int i = 0; i < 4; i++) fifo_op(1'b1, 1'b0, 32'hB000 + DW'(i));
    for (int i = 0; i < 3; i++) fifo_op(1'b1, 1'b1, 32'hC000 + DW'(i));
    axi_read(STATUS_ADDR);
    for (int i = 0; i < 4; i++) fifo_op(1'b0, 1'b1, '0);

    axi_write(CONTROL_ADDR, 32'h1, 4'hF, 1'b1);
    axi_write(CONTROL_ADDR, 32'h0, 4'hE, 1'b0);
    axi_read(CONTROL_ADDR);
    axi_write(STATUS_ADDR, 32'hFFFF_FFFF, 4'hF, 1'b0);
    axi_read(12'h006);
    axi_read(12'h010);
    axi_write(12'h003, 32'hFFFF_FFFE, 4'hF, 1'b0);
    axi_read(CONTROL_ADDR);
    axi_write(CONTROL_ADDR, 32'h1, 4'h1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int thr = (i < 200) ? 7 : 3;
      fifo_op($urandom_range(0, 9) < thr, $urandom_range(0, 9) >= thr, $urandom);
      if (i % 40 == 39) axi_read(STATUS_ADDR);
      if (i % 97 == 50) begin
        axi_write(CONTROL_ADDR, $urandom, 4'($urandom), 1'b0);
        axi_read(CONTROL_ADDR);
      end
    end

    axi_write(CONTROL_ADDR, 32'h1, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) fifo_op(1'b1, 1'b0, 32'hE000 + DW'(i));
    S_AXI_AWADDR = CONTROL_ADDR; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int n = 0; n < 20 && !S_AXI_AWREADY; n++) @(negedge ACLK);
    ARESETn = 1'b0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    exp_b = 0; model_en = 1'b0; model_q.delete(); model_dout = '0;
    repeat (3) tick();
    ARESETn = 1'b1;
    repeat (4) tick();
    check("reset_dout", data_out, '0);
    axi_read(STATUS_ADDR);
    axi_read(CONTROL_ADDR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
